mqst_frame_rx: RTL and testbench
================================

// Module: mqst_frame_rx
// PURPOSE
//  Frame receiver directly downstream of the Manchester demodulator.
//  - Consumes the decoded bit stream (one bit_in_valid pulse per recovered bit, nominally 1 per 16 clk).
//  - Hunts for a 16-bit sync word, then parses LEN, payload and (optionally) a CRC-8.
//  - Emits payload bytes plus a per-frame status pulse and statistics counters.
// PARAMETERS
//  SYNC_WORD  16'hEB90  sync pattern, MSB first; must be non-zero
//  MAX_LEN    8'd64     largest legal LEN value
//  TIMEOUT    64        clk cycles with no bit_in_valid before a mid-frame abort
// PORTS
//  clk           in   1   system clock (32 MHz)
//  rst           in   1   asynchronous reset, active-high
//  bit_in        in   1   decoded bit, sampled only when bit_in_valid=1
//  bit_in_valid  in   1   single-cycle strobe, one per bit
//  byte_data     out  8   payload byte, MSB received first
//  byte_valid    out  1   1-cycle strobe qualifying byte_data
//  byte_sof      out  1   with byte_valid, marks first payload byte
//  byte_eof      out  1   with byte_valid, marks last payload byte
//  frame_done    out  1   1-cycle strobe: frame finished or aborted
//  frame_ok      out  1   valid with frame_done: 1 = good frame
//  err_code      out  2   valid with frame_done: 0 none, 1 bad LEN, 2 CRC fail, 3 timeout
//  good_cnt      out  16  good frames received; wraps at 16'hFFFF
//  err_cnt       out  16  aborted or failed frames; wraps
// BEHAVIOUR
//  Reset
//   - All outputs and counters are 0; state is HUNT; shift register is 0.
//   - Reset mid-frame discards the frame with no frame_done pulse.
//  Bit path
//   - Every bit_in_valid shifts bit_in into a 16-bit shift register (LSB side).
//   - A 3-bit bit counter tracks byte boundaries.
//  FSM states: HUNT -> LEN -> DATA -> CRC -> HUNT
//   - HUNT: after each bit, if shreg == SYNC_WORD, go to LEN. Matching is bit-aligned and sliding. Bit counter is cleared. No timeout in HUNT.
//   - LEN: on the 8th bit, latch LEN.
//     - LEN==0 or LEN>MAX_LEN: frame_done=1, err_code=1, go to HUNT.
//     - Otherwise go to DATA.
//   - DATA: on each 8th bit, next cycle byte_valid=1 and byte_data = assembled byte.
//     - byte_sof on the 1st byte; byte_eof on byte number LEN.
//     - After byte LEN, go to CRC.
//   - CRC: on the 8th bit compare the received byte with the running CRC.
//     - Match: frame_ok=1, err_code=0.
//     - Mismatch: frame_ok=0, err_code=2.
//     - In both cases frame_done=1, then go to HUNT.
//  Latency
//   - byte_valid and frame_done assert exactly 1 cycle after the bit_in_valid that carried the byte's last bit.
//  Timeout
//   - Idle counter clears on every bit_in_valid; it counts only in LEN, DATA and CRC.
//   - At TIMEOUT-1: frame_done=1, err_code=3, go to HUNT. No byte_eof is issued for the truncated frame.
//   - A bit_in_valid in the same cycle clears the counter, so that bit wins.
//  Returning to HUNT clears shreg to 0, so the frame's tail cannot alias as a sync.
//  CRC-8
//   - Poly x^8+x^2+x+1 (0x07), init 0x00, no reflection, no final XOR.
//   - Computed bit-serially over the LEN byte and the payload.
//  Counters
//   - good_cnt increments on frame_done & frame_ok.
//   - err_cnt increments on frame_done & !frame_ok.
// CONFIGURATION
//  MQST_CRC_EN defined
//   - The CRC state exists, exactly as described above.
//  MQST_CRC_EN undefined
//   - No CRC byte is present on the line and the CRC logic is removed.
//   - frame_done/frame_ok=1 in the same cycle as the byte_eof strobe; err_code 2 never occurs.
// STRUCTURE
//  Package mqst_pkg holds:
//   - FSM state encoding (ST_HUNT, ST_LEN, ST_DATA, ST_CRC).
//   - err_code constants (ERR_NONE, ERR_LEN, ERR_CRC, ERR_TMO).
//   - CRC8_POLY = 8'h07.
//  Sub-module mqst_crc8_serial: clear, bit_en, bit_in -> crc[7:0], one bit per enable. It is instantiated only under MQST_CRC_EN.
// TESTING
//  Bits are driven 1 per 16 clk, MSB first. Tests 1-4 and 6 apply to the MQST_CRC_EN build.
//  1. Good frame EB 90 01 A5 67:
//     - byte_valid once, data 0xA5, with sof=eof=1.
//     - frame_done, frame_ok=1, err_code=0; good_cnt 0->1.
//  2. Same frame with CRC 0x66:
//     - byte 0xA5 is still emitted.
//     - frame_done, frame_ok=0, err_code=2; err_cnt=1.
//  3. EB 90 00, and separately EB 90 41 (LEN 65 > 64):
//     - err_code=1 each time; no byte_valid; err_cnt +1 each.
//  4. EB 90 02 11, then bits stop for 64 clk:
//     - one byte 0x11 with sof=1, eof=0.
//     - frame_done with err_code=3.
//     - A following good frame is then received correctly.
//  5. Build without MQST_CRC_EN, stream EB 90 02 11 22:
//     - bytes 0x11 (sof) and 0x22 (eof).
//     - frame_ok=1 in the same cycle as eof.
//  6. Stream 5 noise bits then EB 90 01 A5 67 (non-byte-aligned sync); separately, rst asserted during the payload:
//     - non-aligned sync: frame is accepted normally.
//     - rst during payload: outputs go to 0 and no frame_done is issued.

Source files
------------

// File: rtl/mqst_pkg.sv
// Shared definitions for the MQST frame receiver: FSM states, error codes and the CRC-8 step.
// Optional feature macro: MQST_CRC_EN (enables the trailing CRC-8 byte check).
package mqst_pkg;

    typedef enum logic [1:0] {
        ST_HUNT = 2'd0,
        ST_LEN  = 2'd1,
        ST_DATA = 2'd2,
        ST_CRC  = 2'd3
    } state_e;

    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_LEN  = 2'd1;
    localparam logic [1:0] ERR_CRC  = 2'd2;
    localparam logic [1:0] ERR_TMO  = 2'd3;

    localparam logic [7:0] CRC8_POLY = 8'h07;

    // One bit of a non-reflected CRC-8, MSB-first, no final XOR.
    function automatic logic [7:0] crc8Step(input logic [7:0] crc, input logic b);
        return {crc[6:0], 1'b0} ^ (((crc[7] ^ b) == 1'b1) ? CRC8_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/mqst_crc8_serial.sv
// Bit-serial CRC-8 (poly 0x07, init 0x00) for the MQST frame receiver.
// Only instantiated when MQST_CRC_EN is defined.
module mqst_crc8_serial
    import mqst_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       bit_en,
    input  logic       bit_in,
    output logic [7:0] crc
);

    logic [7:0] crc_q;
    logic [7:0] crc_d;

    // Next CRC value: clear wins over a bit, otherwise fold in one bit per enable.
    always_comb begin
        crc_d = crc_q;
        if (clear) begin
            crc_d = 8'h00;
        end else if (bit_en) begin
            crc_d = crc8Step(crc_q, bit_in);
        end
    end

    // CRC register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crc_q <= 8'h00;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc = crc_q;

endmodule

// File: rtl/mqst_frame_rx.sv
// MQST frame receiver: hunts a 16-bit sync word in the demodulated bit stream, then parses
// LEN, payload bytes and, when MQST_CRC_EN is defined, a trailing CRC-8 byte.
// Without MQST_CRC_EN the frame completes on the last payload byte.
module mqst_frame_rx
    import mqst_pkg::*;
#(
    parameter logic [15:0] SYNC_WORD = 16'hEB90,
    parameter logic [7:0]  MAX_LEN   = 8'd64,
    parameter int          TIMEOUT   = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        bit_in,
    input  logic        bit_in_valid,
    output logic [7:0]  byte_data,
    output logic        byte_valid,
    output logic        byte_sof,
    output logic        byte_eof,
    output logic        frame_done,
    output logic        frame_ok,
    output logic [1:0]  err_code,
    output logic [15:0] good_cnt,
    output logic [15:0] err_cnt
);

    localparam int IDLE_W = $clog2(TIMEOUT + 1);

    state_e              state_q;
    logic [15:0]         shreg_q;
    logic [2:0]          bitcnt_q;
    logic [7:0]          len_q;
    logic [7:0]          bytecnt_q;
    logic [IDLE_W-1:0]   idle_q;

    logic [7:0]          byte_data_q;
    logic                byte_valid_q;
    logic                byte_sof_q;
    logic                byte_eof_q;
    logic                frame_done_q;
    logic                frame_ok_q;
    logic [1:0]          err_code_q;
    logic [15:0]         good_cnt_q;
    logic [15:0]         err_cnt_q;

    logic [15:0]         shreg_d;
    logic [7:0]          rx_byte;
    logic                byte_end;
    logic                sync_hit;
    logic                timeout_hit;

    assign shreg_d     = {shreg_q[14:0], bit_in};
    assign rx_byte     = {shreg_q[6:0], bit_in};
    assign byte_end    = bit_in_valid && (bitcnt_q == 3'd7);
    assign sync_hit    = (state_q == ST_HUNT) && (shreg_q == SYNC_WORD);
    assign timeout_hit = (state_q != ST_HUNT) && !bit_in_valid &&
                         (idle_q == IDLE_W'(TIMEOUT - 1));

`ifdef MQST_CRC_EN
    logic [7:0] crc_val;
    logic       crc_clear;
    logic       crc_bit_en;

    // The LEN bit can land in the same cycle the sync is seen, so that case keeps the CRC live.
    assign crc_clear  = (state_q == ST_HUNT) && !sync_hit;
    assign crc_bit_en = bit_in_valid &&
                        (sync_hit || (state_q == ST_LEN) || (state_q == ST_DATA));

    mqst_crc8_serial u_crc (
        .clk    (clk),
        .rst    (rst),
        .clear  (crc_clear),
        .bit_en (crc_bit_en),
        .bit_in (bit_in),
        .crc    (crc_val)
    );
`endif

    // Frame FSM with registered strobes, bit/byte bookkeeping, idle timeout and statistics.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_HUNT;
            shreg_q      <= 16'h0000;
            bitcnt_q     <= 3'd0;
            len_q        <= 8'd0;
            bytecnt_q    <= 8'd0;
            idle_q       <= '0;
            byte_data_q  <= 8'd0;
            byte_valid_q <= 1'b0;
            byte_sof_q   <= 1'b0;
            byte_eof_q   <= 1'b0;
            frame_done_q <= 1'b0;
            frame_ok_q   <= 1'b0;
            err_code_q   <= ERR_NONE;
            good_cnt_q   <= 16'd0;
            err_cnt_q    <= 16'd0;
        end else begin
            byte_valid_q <= 1'b0;
            byte_sof_q   <= 1'b0;
            byte_eof_q   <= 1'b0;
            frame_done_q <= 1'b0;
            frame_ok_q   <= 1'b0;
            err_code_q   <= ERR_NONE;

            good_cnt_q <= good_cnt_q + 16'(frame_done_q & frame_ok_q);
            err_cnt_q  <= err_cnt_q + 16'(frame_done_q & ~frame_ok_q);

            if (bit_in_valid || (state_q == ST_HUNT)) begin
                idle_q <= '0;
            end else begin
                idle_q <= idle_q + IDLE_W'(1);
            end

            if (bit_in_valid) begin
                shreg_q  <= shreg_d;
                bitcnt_q <= bitcnt_q + 3'd1;
            end

            if (timeout_hit) begin
                frame_done_q <= 1'b1;
                err_code_q   <= ERR_TMO;
                state_q      <= ST_HUNT;
                shreg_q      <= 16'h0000;
                bitcnt_q     <= 3'd0;
            end else begin
                case (state_q)
                    ST_HUNT: begin
                        if (sync_hit) begin
                            state_q  <= ST_LEN;
                            bitcnt_q <= bit_in_valid ? 3'd1 : 3'd0;
                        end else begin
                            bitcnt_q <= 3'd0;
                        end
                    end
                    ST_LEN: begin
                        if (byte_end) begin
                            len_q     <= rx_byte;
                            bytecnt_q <= 8'd0;
                            if ((rx_byte == 8'd0) || (rx_byte > MAX_LEN)) begin
                                frame_done_q <= 1'b1;
                                err_code_q   <= ERR_LEN;
                                state_q      <= ST_HUNT;
                                shreg_q      <= 16'h0000;
                            end else begin
                                state_q <= ST_DATA;
                            end
                        end
                    end
                    ST_DATA: begin
                        if (byte_end) begin
                            byte_valid_q <= 1'b1;
                            byte_data_q  <= rx_byte;
                            byte_sof_q   <= (bytecnt_q == 8'd0);
                            bytecnt_q    <= bytecnt_q + 8'd1;
                            if (bytecnt_q == (len_q - 8'd1)) begin
                                byte_eof_q <= 1'b1;
`ifdef MQST_CRC_EN
                                state_q    <= ST_CRC;
`else
                                frame_done_q <= 1'b1;
                                frame_ok_q   <= 1'b1;
                                state_q      <= ST_HUNT;
                                shreg_q      <= 16'h0000;
`endif
                            end
                        end
                    end
`ifdef MQST_CRC_EN
                    ST_CRC: begin
                        if (byte_end) begin
                            frame_done_q <= 1'b1;
                            if (rx_byte == crc_val) begin
                                frame_ok_q <= 1'b1;
                                err_code_q <= ERR_NONE;
                            end else begin
                                frame_ok_q <= 1'b0;
                                err_code_q <= ERR_CRC;
                            end
                            state_q <= ST_HUNT;
                            shreg_q <= 16'h0000;
                        end
                    end
`endif
                    default: begin
                        state_q <= ST_HUNT;
                        shreg_q <= 16'h0000;
                    end
                endcase
            end
        end
    end

    assign byte_data  = byte_data_q;
    assign byte_valid = byte_valid_q;
    assign byte_sof   = byte_sof_q;
    assign byte_eof   = byte_eof_q;
    assign frame_done = frame_done_q;
    assign frame_ok   = frame_ok_q;
    assign err_code   = err_code_q;
    assign good_cnt   = good_cnt_q;
    assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_mqst_frame_rx.sv
// Scoreboard testbench for mqst_frame_rx. Stimulus pushes expected bytes/frame results into a
// queue; a monitor pops and compares whenever the DUT strobes byte_valid or frame_done.
// Vectors adapt to whether MQST_CRC_EN is defined.
module tb_mqst_frame_rx;

    logic        clk;
    logic        rst;
    logic        bit_in;
    logic        bit_in_valid;
    logic [7:0]  byte_data;
    logic        byte_valid;
    logic        byte_sof;
    logic        byte_eof;
    logic        frame_done;
    logic        frame_ok;
    logic [1:0]  err_code;
    logic [15:0] good_cnt;
    logic [15:0] err_cnt;

    typedef struct {
        bit         isFrame;
        logic [7:0] data;
        bit         sof;
        bit         eof;
        bit         ok;
        logic [1:0] err;
        bit         withEof;
    } exp_t;

    exp_t expQ[$];
    int   compared = 0;
    int   mismatched = 0;
    int   modelGood = 0;
    int   modelErr = 0;

    mqst_frame_rx dut (
        .clk          (clk),
        .rst          (rst),
        .bit_in       (bit_in),
        .bit_in_valid (bit_in_valid),
        .byte_data    (byte_data),
        .byte_valid   (byte_valid),
        .byte_sof     (byte_sof),
        .byte_eof     (byte_eof),
        .frame_done   (frame_done),
        .frame_ok     (frame_ok),
        .err_code     (err_code),
        .good_cnt     (good_cnt),
        .err_cnt      (err_cnt)
    );

    // 100 MHz-style free-running clock; only relative timing matters here.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic pushByte(input logic [7:0] d, input bit sof, input bit eof);
        exp_t e;
        e = '{isFrame: 1'b0, data: d, sof: sof, eof: eof, ok: 1'b0, err: 2'd0, withEof: 1'b0};
        expQ.push_back(e);
    endtask

    task automatic pushFrame(input bit ok, input logic [1:0] err, input bit withEof);
        exp_t e;
        e = '{isFrame: 1'b1, data: 8'd0, sof: 1'b0, eof: 1'b0, ok: ok, err: err, withEof: withEof};
        expQ.push_back(e);
    endtask

    // One bit per 16 clocks, valid for a single cycle.
    task automatic applyStimulus(input logic b);
        @(negedge clk);
        bit_in       = b;
        bit_in_valid = 1'b1;
        @(negedge clk);
        bit_in_valid = 1'b0;
        repeat (14) @(negedge clk);
    endtask

    task automatic sendByte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            applyStimulus(b[i]);
        end
    endtask

    task automatic idleCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic checkCounters(input string tag);
        checkOutput({tag, "_good_cnt"}, {16'd0, good_cnt}, modelGood);
        checkOutput({tag, "_err_cnt"}, {16'd0, err_cnt}, modelErr);
    endtask

    // Frame EB 90 01 A5 (+ CRC 0x67 when the CRC byte is on the line).
    task automatic sendGoodFrame();
        pushByte(8'hA5, 1'b1, 1'b1);
`ifdef MQST_CRC_EN
        pushFrame(1'b1, 2'd0, 1'b0);
`else
        pushFrame(1'b1, 2'd0, 1'b1);
`endif
        sendByte(8'hEB);
        sendByte(8'h90);
        sendByte(8'h01);
        sendByte(8'hA5);
`ifdef MQST_CRC_EN
        sendByte(8'h67);
`endif
        modelGood++;
    endtask

    // Monitor: compare every byte/frame strobe against the head of the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (byte_valid) begin
                if ((expQ.size() == 0) || expQ[0].isFrame) begin
                    compared++;
                    mismatched++;
                    $display("[TB] FAIL unexpected_byte: got byte 0x%02h, expected no byte here", byte_data);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("byte_data", {24'd0, byte_data}, {24'd0, e.data});
                    checkOutput("byte_sof", {31'd0, byte_sof}, {31'd0, e.sof});
                    checkOutput("byte_eof", {31'd0, byte_eof}, {31'd0, e.eof});
                end
            end
            if (frame_done) begin
                if ((expQ.size() == 0) || !expQ[0].isFrame) begin
                    compared++;
                    mismatched++;
                    $display("[TB] FAIL unexpected_frame_done: got ok=%0d err=%0d, expected no frame_done here",
                             frame_ok, err_code);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("frame_ok", {31'd0, frame_ok}, {31'd0, e.ok});
                    checkOutput("err_code", {30'd0, err_code}, {30'd0, e.err});
                    if (e.withEof) begin
                        checkOutput("frame_with_eof", {31'd0, byte_valid & byte_eof}, 32'd1);
                    end
                end
            end
        end
    end

    // Directed scenario sequence.
    initial begin
        rst          = 1'b1;
        bit_in       = 1'b0;
        bit_in_valid = 1'b0;
        repeat (5) @(negedge clk);

        checkOutput("reset_byte_valid", {31'd0, byte_valid}, 32'd0);
        checkOutput("reset_byte_data", {24'd0, byte_data}, 32'd0);
        checkOutput("reset_frame_done", {31'd0, frame_done}, 32'd0);
        checkCounters("reset");

        rst = 1'b0;
        idleCycles(5);

`ifdef MQST_CRC_EN
        $display("[TB] build with CRC byte");
        sendGoodFrame();
        idleCycles(40);
        checkCounters("good_frame");

        pushByte(8'hA5, 1'b1, 1'b1);
        pushFrame(1'b0, 2'd2, 1'b0);
        sendByte(8'hEB); sendByte(8'h90); sendByte(8'h01); sendByte(8'hA5); sendByte(8'h66);
        modelErr++;
        idleCycles(40);
        checkCounters("bad_crc");
`else
        $display("[TB] build without CRC byte");
        pushByte(8'h11, 1'b1, 1'b0);
        pushByte(8'h22, 1'b0, 1'b1);
        pushFrame(1'b1, 2'd0, 1'b1);
        sendByte(8'hEB); sendByte(8'h90); sendByte(8'h02); sendByte(8'h11); sendByte(8'h22);
        modelGood++;
        idleCycles(40);
        checkCounters("two_byte_frame");
`endif

        pushFrame(1'b0, 2'd1, 1'b0);
        sendByte(8'hEB); sendByte(8'h90); sendByte(8'h00);
        modelErr++;
        idleCycles(40);
        checkCounters("len_zero");

        pushFrame(1'b0, 2'd1, 1'b0);
        sendByte(8'hEB); sendByte(8'h90); sendByte(8'h41);
        modelErr++;
        idleCycles(40);
        checkCounters("len_too_big");

        pushByte(8'h11, 1'b1, 1'b0);
        pushFrame(1'b0, 2'd3, 1'b0);
        sendByte(8'hEB); sendByte(8'h90); sendByte(8'h02); sendByte(8'h11);
        modelErr++;
        idleCycles(100);
        checkCounters("timeout");

        sendGoodFrame();
        idleCycles(40);
        checkCounters("after_timeout");

        applyStimulus(1'b1); applyStimulus(1'b0); applyStimulus(1'b1);
        applyStimulus(1'b1); applyStimulus(1'b0);
        sendGoodFrame();
        idleCycles(40);
        checkCounters("unaligned_sync");

        sendByte(8'hEB); sendByte(8'h90); sendByte(8'h02);
        applyStimulus(1'b0); applyStimulus(1'b0); applyStimulus(1'b0); applyStimulus(1'b1);
        @(negedge clk);
        rst = 1'b1;
        modelGood = 0;
        modelErr  = 0;
        repeat (3) @(negedge clk);
        checkOutput("midreset_byte_data", {24'd0, byte_data}, 32'd0);
        checkOutput("midreset_frame_done", {31'd0, frame_done}, 32'd0);
        checkCounters("midreset");
        rst = 1'b0;
        idleCycles(200);

        sendGoodFrame();
        idleCycles(40);
        checkCounters("after_reset");

        checkOutput("scoreboard_empty", expQ.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
